add_serial: RTL and testbench

ADD_SERIAL -- requirements
Module: add_serial

---
 rtl/add_serial.sv | 134 +++++++++++++
 tb/tb_add_serial.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/add_serial.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock over N = WIDTH/CHUNK cycles,
// then presents a registered result with carry, signed overflow and zero flags.
module add_serial #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] entry0,
  input  logic [WIDTH-1:0] entry1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned N    = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH ||
      ((CHUNK == 0) ? 1 : (WIDTH % CHUNK)) != 0) begin : g_bad_param
    $error("add_serial: illegal WIDTH/CHUNK combination");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic              cy_q, cy_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d;

  int unsigned       base;
  logic [CHUNK-1:0]  a_chunk, b_chunk;
  logic [CHUNK:0]    chunk_full;
  logic              cin_msb;

  // Datapath for the chunk selected by the counter
  always_comb begin
    base       = 32'(cnt_q) * CHUNK;
    a_chunk    = a_q[base +: CHUNK];
    b_chunk    = b_q[base +: CHUNK];
    chunk_full = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, cy_q};
    // Carry into the chunk's top bit recovered from its sum bit
    cin_msb    = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_full[CHUNK-1];
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    cy_d     = cy_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StBusy;
          a_d     = entry0;
          b_d     = sub ? ~entry1 : entry1;
          cy_d    = sub;
          cnt_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StBusy: begin
        sum_d[base +: CHUNK] = chunk_full[CHUNK-1:0];
        cy_d  = chunk_full[CHUNK];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(N - 1)) begin
          state_d  = StDone;
          result_d = sum_d;
          carry_d  = chunk_full[CHUNK];
          ovf_d    = cin_msb ^ chunk_full[CHUNK];
          zero_d   = (sum_d == '0);
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StBusy);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      cy_q     <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      cy_q     <= cy_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_add_serial.sv
// Directed bench for add_serial (WIDTH=32, CHUNK=8): scoreboard of expected results
// pushed at start and popped at each done pulse.
module tb_add_serial;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [31:0] entry0 = '0;
  logic [31:0] entry1 = '0;
  logic        busy, done, carry, overflow, zero;
  logic [31:0] result;

  add_serial #(.WIDTH(32), .CHUNK(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sub      (sub),
    .entry0   (entry0),
    .entry1   (entry1),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry    (carry),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  exp_t        sb[$];
  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] last_res = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain 33-bit arithmetic
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t        e;
    logic [31:0] bb;
    logic [32:0] full;
    bb   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {32'd0, s};
    e.res = full[31:0];
    e.c   = full[32];
    e.v   = (a[31] == bb[31]) && (full[31] != a[31]);
    e.z   = (full[31:0] == 32'd0);
    return e;
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    entry0 = a;
    entry1 = b;
    sub    = s;
    start  = 1'b1;
    sb.push_back(model(a, b, s));
  endtask

  // Called after the accept edge plus k0 more edges; expects done at edge 4.
  task automatic wait_done(input int k0, input string tag);
    exp_t e;
    bit   seen = 0;
    for (int k = k0 + 1; k <= 20 && !seen; k++) begin
      tick();
      if (done) begin
        seen = 1;
        check({tag, " latency"}, 32'(k), 32'd4);
        check({tag, " busy@done"}, {31'd0, busy}, 32'd0);
        if (sb.size() == 0) begin
          check({tag, " sb empty"}, 32'd0, 32'd1);
        end else begin
          e = sb.pop_front();
          check({tag, " result"}, result, e.res);
          check({tag, " carry"}, {31'd0, carry}, {31'd0, e.c});
          check({tag, " overflow"}, {31'd0, overflow}, {31'd0, e.v});
          check({tag, " zero"}, {31'd0, zero}, {31'd0, e.z});
          last_res = e.res;
        end
      end else begin
        check({tag, " busy"}, {31'd0, busy}, 32'd1);
        check({tag, " hold"}, result, last_res);
      end
    end
    if (!seen) check({tag, " timeout"}, 32'd0, 32'd1);
    tick();
    check({tag, " done pulse"}, {31'd0, done}, 32'd0);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s,
                     input string tag);
    start_op(a, b, s);
    tick();
    start = 1'b0;
    check({tag, " busy@0"}, {31'd0, busy}, 32'd1);
    wait_done(0, tag);
  endtask

  initial begin
    #12;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst result", result, 32'd0);
    check("rst flags", {29'd0, carry, overflow, zero}, 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;

    run(32'd7, 32'd5, 1'b0, "7+5");
    run(32'hFFFF_FFFF, 32'd1, 1'b0, "ffffffff+1");
    run(32'h7FFF_FFFF, 32'd1, 1'b0, "7fffffff+1");
    run(32'd5, 32'd7, 1'b1, "5-7");
    run(32'd7, 32'd5, 1'b1, "7-5");
    run(32'h8000_0000, 32'd1, 1'b1, "80000000-1");

    // start during BUSY must be ignored
    start_op(32'd7, 32'd5, 1'b0);
    tick();
    start  = 1'b0;
    tick();
    entry0 = 32'd100;
    entry1 = 32'd200;
    sub    = 1'b1;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    wait_done(2, "ignore");

    // start held through DONE: second op begins with no IDLE cycle
    start_op(32'd1, 32'd1, 1'b0);
    sb.push_back(model(32'd1, 32'd1, 1'b0));
    tick();
    wait_done(0, "b2b first");
    start = 1'b0;
    check("b2b no idle", {31'd0, busy}, 32'd1);
    wait_done(0, "b2b second");

    // asynchronous reset mid-operation
    entry0 = 32'd9;
    entry1 = 32'd9;
    sub    = 1'b0;
    start  = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort result", result, 32'd0);
    check("abort flags", {29'd0, carry, overflow, zero}, 32'd1);
    last_res = '0;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("abort no done", {31'd0, done}, 32'd0);
    end
    run(32'd3, 32'd4, 1'b0, "3+4 after rst");

    check("sb drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
